// File: rtl/hamming_rx_if.sv
// Serial Hamming(7,4) receiver bus: serial input qualified by strobe,
// decoded frame outputs and status pulses.
interface hamming_rx_if;
  logic       data_line;
  logic       strobe;
  logic [1:7] data_out;
  logic [3:0] nibble;
  logic       valid;
  logic       err_corr;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport master (
    output data_line, strobe,
    input  data_out, nibble, valid, err_corr, frame_err, err_cnt
  );

  modport slave (
    input  data_line, strobe,
    output data_out, nibble, valid, err_corr, frame_err, err_cnt
  );
endinterface

// File: rtl/hamming_rx.sv
// Serial Hamming(7,4) frame receiver.
// Collects 7 strobe-qualified bits (bit 1 first), computes the syndrome and
// registers the codeword, data nibble and error flag; counts frames with a
// nonzero syndrome (saturating at 255).
// Build option HAMMING_CORRECT_EN: when defined, the bit addressed by a
// nonzero syndrome is inverted before data_out/nibble are registered.
//
// state | meaning
// IDLE  | waiting for strobe; strobe high samples bit 1
// SHIFT | collecting bits 2..7; strobe low aborts the frame
// DONE  | valid high; strobe high samples bit 1 of the next frame
module hamming_rx (
  input  logic clk,
  input  logic rst,
  hamming_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [5:0] hold;
  logic [1:7] cw;
  logic [1:7] cw_fix;
  logic [2:0] syn;
  logic       start, shift, last, abort;

  // Bits 1..6 live in hold (bit 1 at the MSB); bit 7 is taken straight
  // from the line on the completing edge.
  assign cw = {hold, bus.data_line};

  assign syn[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
  assign syn[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
  assign syn[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];

  assign bus.valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.strobe) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.strobe) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (bit_cnt == 3'd6) begin
          last      = 1'b1;
          state_nxt = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        if (bus.strobe) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Optional single-bit correction at the position named by the syndrome.
  always_comb begin
    cw_fix = cw;
`ifdef HAMMING_CORRECT_EN
    for (int i = 1; i <= 7; i++) begin
      if (syn == 3'(i)) cw_fix[i] = ~cw[i];
    end
`endif
  end

  // Bit counter and shift register for the frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= 3'd0;
      hold    <= 6'd0;
    end else if (start) begin
      bit_cnt <= 3'd1;
      hold    <= {5'd0, bus.data_line};
    end else if (shift) begin
      bit_cnt <= bit_cnt + 3'd1;
      hold    <= {hold[4:0], bus.data_line};
    end else if (last || abort) begin
      bit_cnt <= 3'd0;
    end
  end

  // Frame results, held until the next completed frame, plus status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out  <= 7'd0;
      bus.nibble    <= 4'd0;
      bus.err_corr  <= 1'b0;
      bus.err_cnt   <= 8'd0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= abort;
      if (last) begin
        bus.data_out <= cw_fix;
        bus.nibble   <= {cw_fix[3], cw_fix[5], cw_fix[6], cw_fix[7]};
        bus.err_corr <= |syn;
        if ((|syn) && (bus.err_cnt != 8'hFF)) bus.err_cnt <= bus.err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_rx.sv
// Self-checking bench for hamming_rx: a bit-queue reference model checked
// every cycle, plus directed frames with hand-computed expectations.
module tb_hamming_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hamming_rx_if bus();

  hamming_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  bit         mq[$];
  logic [1:7] m_data = '0;
  logic [3:0] m_nib  = '0;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_corr  = 1'b0;
  int         m_cnt   = 0;

  // observed events
  int v_cyc[$];
  int valid_total = 0;
  int ferr_total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:7] encode(input logic [3:0] d);
    logic [1:7] c;
    c    = '0;
    c[3] = d[3];
    c[5] = d[2];
    c[6] = d[1];
    c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  // Decode a complete 7-bit frame: the syndrome is the XOR of the
  // positions of all set bits.
  function automatic void model_decode();
    bit c[1:7];
    int s;
    s = 0;
    for (int i = 1; i <= 7; i++) begin
      c[i] = mq[i-1];
      if (c[i]) s = s ^ i;
    end
    m_corr = (s != 0);
    if (s != 0 && m_cnt < 255) m_cnt++;
`ifdef HAMMING_CORRECT_EN
    if (s != 0) c[s] = ~c[s];
`endif
    for (int i = 1; i <= 7; i++) m_data[i] = c[i];
    m_nib = {c[3], c[5], c[6], c[7]};
  endfunction

  // Reference model: frames are runs of 7 strobed bits; a strobe drop with a
  // partial frame pending is an abort.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_data  = '0;
      m_nib   = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_corr  = 1'b0;
      m_cnt   = 0;
    end else begin
      cyc++;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      if (bus.strobe) begin
        mq.push_back(bus.data_line);
        if (mq.size() == 7) begin
          model_decode();
          mq.delete();
          m_valid = 1'b1;
        end
      end else if (mq.size() != 0) begin
        m_ferr = 1'b1;
        mq.delete();
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("valid",     32'(bus.valid),     32'(m_valid));
      check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      check("data_out",  32'(bus.data_out),  32'(m_data));
      check("nibble",    32'(bus.nibble),    32'(m_nib));
      check("err_corr",  32'(bus.err_corr),  32'(m_corr));
      check("err_cnt",   32'(bus.err_cnt),   m_cnt);
      if (bus.valid) begin
        valid_total++;
        v_cyc.push_back(cyc);
      end
      if (bus.frame_err) ferr_total++;
    end
  end

  task automatic send(input logic [1:7] cw, input int n, input bit drop);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      bus.strobe    = 1'b1;
      bus.data_line = cw[i];
    end
    if (drop) begin
      @(posedge clk); #1;
      bus.strobe    = 1'b0;
      bus.data_line = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.strobe    = 1'b0;
      bus.data_line = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [1:7] cw;
    int fe, vt, kind, n, pos;
    bus.strobe    = 1'b0;
    bus.data_line = 1'b0;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(bus.data_out), 0);
    check("rst_valid",    32'(bus.valid),    0);
    check("rst_err_cnt",  32'(bus.err_cnt),  0);
    @(negedge clk) rst = 1'b1;
    idle(2);

    // clean frame
    send(7'b0110011, 7, 1);
    check("clean_valid",    32'(bus.valid),    1);
    check("clean_data",     32'(bus.data_out), 32'(7'b0110011));
    check("clean_nibble",   32'(bus.nibble),   32'(4'b1011));
    check("clean_err_corr", 32'(bus.err_corr), 0);
    check("clean_err_cnt",  32'(bus.err_cnt),  0);
    idle(2);

    // single error at position 5
    send(7'b0110111, 7, 1);
`ifdef HAMMING_CORRECT_EN
    check("single_data",   32'(bus.data_out), 32'(7'b0110011));
    check("single_nibble", 32'(bus.nibble),   32'(4'b1011));
`else
    check("single_data",   32'(bus.data_out), 32'(7'b0110111));
    check("single_nibble", 32'(bus.nibble),   32'(4'b1111));
`endif
    check("single_err_corr", 32'(bus.err_corr), 1);
    check("single_err_cnt",  32'(bus.err_cnt),  1);
    idle(2);

    // error at position 6, then back-to-back clean frame
    send(7'b1010111, 7, 0);
    @(posedge clk); #1;
`ifdef HAMMING_CORRECT_EN
    check("b2b_first_data",   32'(bus.data_out), 32'(7'b1010101));
    check("b2b_first_nibble", 32'(bus.nibble),   32'(4'b1101));
`else
    check("b2b_first_data",   32'(bus.data_out), 32'(7'b1010111));
    check("b2b_first_nibble", 32'(bus.nibble),   32'(4'b1111));
`endif
    check("b2b_first_err_corr", 32'(bus.err_corr), 1);
    bus.data_line = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      @(posedge clk); #1;
      bus.data_line = cw_bit(7'b0110011, i);
    end
    @(posedge clk); #1;
    bus.strobe = 1'b0;
    check("b2b_second_valid",    32'(bus.valid),    1);
    check("b2b_second_data",     32'(bus.data_out), 32'(7'b0110011));
    check("b2b_second_err_corr", 32'(bus.err_corr), 0);
    check("b2b_err_cnt",         32'(bus.err_cnt),  2);
    @(posedge clk); #1;
    if (v_cyc.size() >= 2)
      check("b2b_spacing", v_cyc[v_cyc.size()-1] - v_cyc[v_cyc.size()-2], 7);
    else
      check("b2b_valid_count", v_cyc.size(), 2);
    idle(2);

    // strobe gap after 4 bits
    fe = ferr_total;
    vt = valid_total;
    send(7'b1111111, 4, 1);
    idle(3);
    check("gap_frame_err", ferr_total, fe + 1);
    check("gap_no_valid",  valid_total, vt);
    check("gap_data_held", 32'(bus.data_out), 32'(7'b0110011));
    send(7'b0110011, 7, 1);
    check("gap_next_valid", 32'(bus.valid),    1);
    check("gap_next_data",  32'(bus.data_out), 32'(7'b0110011));
    idle(2);

    // reset after bit 3
    fe = ferr_total;
    vt = valid_total;
    send(7'b1011010, 3, 0);
    @(posedge clk); #2;
    rst        = 1'b0;
    bus.strobe = 1'b0;
    #1;
    check("rstmid_data",      32'(bus.data_out),  0);
    check("rstmid_nibble",    32'(bus.nibble),    0);
    check("rstmid_err_cnt",   32'(bus.err_cnt),   0);
    check("rstmid_valid",     32'(bus.valid),     0);
    check("rstmid_frame_err", 32'(bus.frame_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle(3);
    check("rstmid_no_ferr",  ferr_total,  fe);
    check("rstmid_no_valid", valid_total, vt);
    send(7'b0010110, 7, 1);
    check("post_rst_valid",    32'(bus.valid),    1);
    check("post_rst_data",     32'(bus.data_out), 32'(7'b0010110));
    check("post_rst_nibble",   32'(bus.nibble),   32'(4'b1110));
    check("post_rst_err_corr", 32'(bus.err_corr), 0);
    idle(2);

    // random frames: clean, single, double errors and truncated frames
    for (int f = 0; f < 200; f++) begin
      cw   = encode(4'($urandom_range(0, 15)));
      kind = $urandom_range(0, 3);
      if (kind >= 1 && kind <= 2) begin
        for (int e = 0; e < kind; e++) begin
          pos = $urandom_range(1, 7);
          cw[pos] = ~cw[pos];
        end
      end
      if (kind == 3) begin
        n = $urandom_range(1, 6);
        send(cw, n, 1);
      end else begin
        send(cw, 7, ($urandom_range(0, 2) != 0));
      end
      if (!bus.strobe) idle($urandom_range(0, 2));
    end
    idle(3);

    // saturation: 260 single-error frames back to back
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int f = 0; f < 260; f++) begin
      cw  = encode(4'($urandom_range(0, 15)));
      pos = $urandom_range(1, 7);
      cw[pos] = ~cw[pos];
      send(cw, 7, 0);
    end
    idle(2);
    check("sat_err_cnt", 32'(bus.err_cnt), 255);
    send(7'b0110111, 7, 1);
    check("sat_hold_err_cnt",  32'(bus.err_cnt),  255);
    check("sat_hold_err_corr", 32'(bus.err_corr), 1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic cw_bit(input logic [1:7] cw, input int i);
    return cw[i];
  endfunction

endmodule

// File: doc/hamming_rx.md
HAMMING_RX -- requirements
Module: hamming_rx

Interface
REQ-001 The block SHALL have ports: clk  input  1  single clock; all state changes on the rising edge.
REQ-002 The block SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: data_line  input  1  serial codeword bit, sampled only when strobe=1.
REQ-004 The block SHALL have ports: strobe  input  1  bit-qualify; high for 7 consecutive cycles per frame.
REQ-005 The block SHALL have ports: data_out  output  [1:7]  received codeword after correction; bit 1 arrives first.
REQ-006 The block SHALL have ports: nibble  output  4  decoded data {c3,c5,c6,c7}.
REQ-007 The block SHALL have ports: valid  output  1  one-cycle pulse; outputs updated this frame.
REQ-008 The block SHALL have ports: err_corr  output  1  nonzero syndrome in last frame; qualified by valid.
REQ-009 The block SHALL have ports: frame_err  output  1  one-cycle pulse; frame aborted by strobe gap.
REQ-010 The block SHALL have ports: err_cnt  output  8  saturating count of frames with nonzero syndrome.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE, with a 3-bit bit counter (0..6).
- IDLE: strobe=1 samples bit 1, bit counter set to 1, go to SHIFT.
REQ-012 In SHIFT, each strobe=1 edge SHALL shift data_line in as the next codeword bit (positions 1..7 in order).
REQ-013 In SHIFT, if strobe=0 before the 7th bit, the block SHALL discard the partial frame, pulse frame_err for 1 cycle and go to IDLE; data_out, nibble and err_corr are unchanged.
REQ-014 On the edge sampling bit 7, the block SHALL:
- compute syndrome s = {s4,s2,s1}: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s4=c4^c5^c6^c7;
- register data_out, nibble and err_corr;
- go to DONE.
REQ-015 valid SHALL be high for exactly the one cycle in DONE, i.e. latency = 1 clock after the 7th bit is sampled.
REQ-016 In DONE, strobe=1 SHALL be sampled as bit 1 of the next frame, go to SHIFT, so back-to-back frames lose no cycle; strobe=0 SHALL go to IDLE.
REQ-017 err_corr SHALL be 1 when s != 0; err_cnt SHALL increment on such frames and saturate at 255.
REQ-018 data_out, nibble and err_corr SHALL hold their values until the next completed frame.
REQ-019 Strobe transitions in IDLE with strobe=0 SHALL have no effect.

Reset
REQ-020 rst=0 SHALL immediately force IDLE, bit counter=0, data_out=7'b0, nibble=0, valid=0, err_corr=0, frame_err=0, err_cnt=0.
REQ-021 A reset asserted mid-frame SHALL discard the partial frame without pulsing frame_err or valid.
REQ-022 After rst rises, the first strobe=1 edge SHALL be treated as bit 1 of a new frame.

Configuration
REQ-023 Macro HAMMING_CORRECT_EN SHALL control correction:
- defined: when s != 0, bit at position s is inverted before data_out and nibble are registered;
- undefined: data_out and nibble carry the raw received bits; err_corr and err_cnt behave identically in both builds.

Verification
REQ-024 The testbench SHALL cover these scenarios:
- Clean frame: bits 0110011 with strobe high for 7 cycles -> valid 1 cycle later, data_out=0110011, nibble=1011, err_corr=0, err_cnt=0.
- Single error: 0110111 with HAMMING_CORRECT_EN -> s=5, data_out=0110011, nibble=1011, err_corr=1, err_cnt=1. Without the macro -> data_out=0110111, nibble=1111, err_corr=1.
- Correctable frame: 1010111 -> s=6, data_out=1010101, nibble=1101 (with HAMMING_CORRECT_EN). Next, back-to-back 0110011 with no strobe gap -> second valid exactly 7 cycles after the first, err_corr=0.
- Gap: strobe low after 4 bits -> frame_err pulse, no valid, data_out holds its previous value. A following full frame decodes normally.
- Reset: rst=0 after bit 3 -> all outputs 0, no valid. Then frame 0010110 -> data_out=0010110, nibble=1110, err_corr=0.
- Saturation: 260 frames each with 1 error -> err_cnt=255 and holds.
